// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode values, instruction field positions,
// fetch FSM state encoding and the fetch timeout limit.
package sisc_pkg;

    // Opcode values (IR[31:28])
    localparam logic [3:0] OP_NOOP   = 4'd0;
    localparam logic [3:0] OP_LOD    = 4'd1;
    localparam logic [3:0] OP_STR    = 4'd2;
    localparam logic [3:0] OP_SWP    = 4'd3;
    localparam logic [3:0] OP_BRA    = 4'd4;
    localparam logic [3:0] OP_BRR    = 4'd5;
    localparam logic [3:0] OP_BNE    = 4'd6;
    localparam logic [3:0] OP_BNR    = 4'd7;
    localparam logic [3:0] OP_ALU_OP = 4'd8;
    localparam logic [3:0] OP_HLT    = 4'd15;

    // Instruction field bit positions
    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;
    localparam int MM_HI  = 27;
    localparam int MM_LO  = 24;
    localparam int RD_HI  = 23;
    localparam int RD_LO  = 20;
    localparam int RS_HI  = 19;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 12;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Last wait-counter value before a stalled fetch is abandoned (15th cycle)
    localparam logic [3:0] WAIT_LAST = 4'd14;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/sisc_br_cond.sv
// Branch condition resolver: decides whether the latched branch is taken
// and whether its target is PC-relative. Non-branch opcodes never take.
module sisc_br_cond
    import sisc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken,
    output logic       is_rel
);

    logic cond;

    assign cond = |(mm & stat);

    // Decode branch kind and polarity of the condition
    always_comb begin
        taken  = 1'b0;
        is_rel = 1'b0;
        case (opcode)
            OP_BRA: taken = cond;
            OP_BRR: begin
                taken  = cond;
                is_rel = 1'b1;
            end
            OP_BNE: taken = !cond;
            OP_BNR: begin
                taken  = !cond;
                is_rel = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sisc_ifetch.sv
// SISC instruction-fetch front end: owns PC and IR, fetches over a
// request/ready handshake, splits IR into fields and resolves branches.
// Optional feature macro: IFETCH_TIMEOUT_EN (abandon a fetch after 15 stalled
// cycles, load a NOOP and set a sticky fetch_err).
module sisc_ifetch
    import sisc_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               fetch_req,
    output logic               fetch_done,
    input  logic               br_eval,
    input  logic [3:0]         stat,
    output logic               im_req,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic               im_ready,
    input  logic [INSTR_W-1:0] im_rdata,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [3:0]         rd,
    output logic [3:0]         rs,
    output logic [3:0]         rt,
    output logic [15:0]        imm,
    output logic [ADDR_W-1:0]  pc,
    output logic               fetch_err
);

    fetch_state_t              state, state_next;
    logic [INSTR_W-1:0]        ir, ir_next;
    logic [ADDR_W-1:0]         pc_next;
    logic                      done_next;
    logic                      br_taken, br_rel;
    logic signed [15:0]        imm_s;
    logic signed [ADDR_W-1:0]  br_off;
    logic [ADDR_W-1:0]         br_target;

`ifdef IFETCH_TIMEOUT_EN
    logic [3:0]                wait_cnt, wait_cnt_next;
    logic                      err_set;
`endif

    // Field split is purely combinational from IR
    assign opcode = ir[OPC_HI:OPC_LO];
    assign mm     = ir[MM_HI:MM_LO];
    assign rd     = ir[RD_HI:RD_LO];
    assign rs     = ir[RS_HI:RS_LO];
    assign rt     = ir[RT_HI:RT_LO];
    assign imm    = ir[IMM_HI:IMM_LO];

    // Request follows state so reset removes it asynchronously
    assign im_req  = (state == ST_REQ);
    assign im_addr = pc;

    sisc_br_cond u_br_cond (
        .opcode (opcode),
        .mm     (mm),
        .stat   (stat),
        .taken  (br_taken),
        .is_rel (br_rel)
    );

    assign imm_s     = $signed(imm);
    assign br_off    = ADDR_W'(imm_s);
    assign br_target = br_rel ? (pc + $unsigned(br_off)) : ADDR_W'(imm);

    // State register
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Next state, IR/PC updates and completion pulse
    always_comb begin
        state_next = state;
        ir_next    = ir;
        pc_next    = pc;
        done_next  = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
        wait_cnt_next = wait_cnt;
        err_set       = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                // Branch first so a simultaneous fetch issues the new PC
                if (br_eval && br_taken) pc_next = br_target;
                if (fetch_req) begin
                    state_next = ST_REQ;
`ifdef IFETCH_TIMEOUT_EN
                    wait_cnt_next = 4'd0;
`endif
                end
            end
            ST_REQ: begin
                if (im_ready) begin
                    ir_next    = im_rdata;
                    pc_next    = pc + ADDR_W'(1);
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
`ifdef IFETCH_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    ir_next    = '0;
                    err_set    = 1'b1;
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt + 4'd1;
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // PC, IR and done pulse registers
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc         <= '0;
            ir         <= '0;
            fetch_done <= 1'b0;
        end else begin
            pc         <= pc_next;
            ir         <= ir_next;
            fetch_done <= done_next;
        end
    end

`ifdef IFETCH_TIMEOUT_EN
    // Wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            wait_cnt  <= 4'd0;
            fetch_err <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_next;
            if (err_set) fetch_err <= 1'b1;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_sisc_ifetch.sv
// Directed testbench for sisc_ifetch with a fetch scoreboard: each issued
// fetch pushes its expected result, a monitor checks it on fetch_done.
module tb_sisc_ifetch;

    logic        clk = 1'b0;
    logic        rst_f;
    logic        fetch_req;
    logic        fetch_done;
    logic        br_eval;
    logic [3:0]  stat;
    logic        im_req;
    logic [15:0] im_addr;
    logic        im_ready;
    logic [31:0] im_rdata;
    logic [3:0]  opcode, mm, rd, rs, rt;
    logic [15:0] imm;
    logic [15:0] pc;
    logic        fetch_err;

    typedef struct {
        logic [31:0] ir;
        logic [15:0] pc;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Memory model controls
    logic        mem_auto = 1'b0;
    int          mem_wait = 0;
    logic [31:0] mem_word = '0;

    sisc_ifetch #(.ADDR_W(16), .INSTR_W(32)) dut (
        .clk        (clk),
        .rst_f      (rst_f),
        .fetch_req  (fetch_req),
        .fetch_done (fetch_done),
        .br_eval    (br_eval),
        .stat       (stat),
        .im_req     (im_req),
        .im_addr    (im_addr),
        .im_ready   (im_ready),
        .im_rdata   (im_rdata),
        .opcode     (opcode),
        .mm         (mm),
        .rd         (rd),
        .rs         (rs),
        .rt         (rt),
        .imm        (imm),
        .pc         (pc),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder: im_ready after mem_wait wait cycles of a request
    initial begin
        int wcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_auto) begin
                if (im_req) begin
                    if (wcnt == mem_wait) begin
                        im_ready = 1'b1;
                        im_rdata = mem_word;
                        wcnt = 0;
                    end else begin
                        im_ready = 1'b0;
                        wcnt++;
                    end
                end else begin
                    im_ready = 1'b0;
                    wcnt = 0;
                end
            end
        end
    end

    // Monitor: every fetch_done must match the oldest expected fetch
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_f === 1'b1 && fetch_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: fetch_done=1 with no fetch outstanding at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_opcode", 64'(opcode), 64'(e.ir[31:28]));
                    chk("sb_mm",     64'(mm),     64'(e.ir[27:24]));
                    chk("sb_rd",     64'(rd),     64'(e.ir[23:20]));
                    chk("sb_rs",     64'(rs),     64'(e.ir[19:16]));
                    chk("sb_rt",     64'(rt),     64'(e.ir[15:12]));
                    chk("sb_imm",    64'(imm),    64'(e.ir[15:0]));
                    chk("sb_pc",     64'(pc),     64'(e.pc));
                    chk("sb_err",    64'(fetch_err), 64'(e.err));
                end
            end
        end
    end

    // Issue one fetch and check handshake timing; result goes to the scoreboard
    task automatic do_fetch(input logic [31:0] word, input logic auto_mem, input int waits,
                            input int exp_lat, input int exp_reqs, input logic [15:0] exp_addr,
                            input logic with_br, input logic [3:0] br_stat,
                            input logic [31:0] exp_ir, input logic [15:0] exp_pc,
                            input logic exp_err);
        exp_t e;
        int   k;
        int   reqs;
        logic seen;
        @(negedge clk);
        mem_word  = word;
        mem_wait  = waits;
        mem_auto  = auto_mem;
        if (!auto_mem) im_ready = 1'b0;
        fetch_req = 1'b1;
        if (with_br) begin
            br_eval = 1'b1;
            stat    = br_stat;
        end
        e.ir  = exp_ir;
        e.pc  = exp_pc;
        e.err = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        br_eval   = 1'b0;
        k    = 1;
        reqs = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            if (im_req) begin
                reqs++;
                chk("im_addr_stable", 64'(im_addr), 64'(exp_addr));
            end
            if (fetch_done) seen = 1'b1;
            else begin
                @(posedge clk);
                @(negedge clk);
                k++;
            end
        end
        chk("done_latency", 64'(k), 64'(exp_lat));
        chk("req_cycles", 64'(reqs), 64'(exp_reqs));
        @(posedge clk);
        @(negedge clk);
        chk("done_one_cycle", 64'(fetch_done), 64'(0));
    endtask

    task automatic do_branch(input logic [3:0] s, input logic [15:0] exp_pc, input string name);
        @(negedge clk);
        br_eval = 1'b1;
        stat    = s;
        @(posedge clk);
        @(negedge clk);
        br_eval = 1'b0;
        chk(name, 64'(pc), 64'(exp_pc));
    endtask

    initial begin
        rst_f     = 1'b0;
        fetch_req = 1'b0;
        br_eval   = 1'b0;
        stat      = 4'd0;
        im_ready  = 1'b0;
        im_rdata  = '0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_im_req",  64'(im_req), 64'(0));
        chk("rst_im_addr", 64'(im_addr), 64'(0));
        chk("rst_pc",      64'(pc), 64'(0));
        chk("rst_opcode",  64'(opcode), 64'(0));
        chk("rst_mm",      64'(mm), 64'(0));
        chk("rst_imm",     64'(imm), 64'(0));
        chk("rst_done",    64'(fetch_done), 64'(0));
        chk("rst_err",     64'(fetch_err), 64'(0));
        rst_f = 1'b1;

        // Zero-wait fetch of 8123_4005 from address 0
        do_fetch(32'h8123_4005, 1'b1, 0, 2, 1, 16'd0, 1'b0, 4'd0, 32'h8123_4005, 16'd1, 1'b0);

        // Three wait cycles: BRA mm=F imm=9 from address 1
        do_fetch(32'h4F00_0009, 1'b1, 3, 5, 4, 16'd1, 1'b0, 4'd0, 32'h4F00_0009, 16'd2, 1'b0);
        do_branch(4'b0001, 16'd9, "bra_taken_pc");

        // BRR mm=0100 imm=-2 at 9 -> pc=10
        do_fetch(32'h5400_FFFE, 1'b1, 0, 2, 1, 16'd9, 1'b0, 4'd0, 32'h5400_FFFE, 16'd10, 1'b0);
        do_branch(4'b0000, 16'd10, "brr_not_taken_pc");
        do_branch(4'b0100, 16'd8, "brr_taken_pc");

        // BNE mm=0001 imm=0x20 at 8 -> pc=9
        do_fetch(32'h6100_0020, 1'b1, 1, 3, 2, 16'd8, 1'b0, 4'd0, 32'h6100_0020, 16'd9, 1'b0);
        do_branch(4'b0001, 16'd9, "bne_not_taken_pc");
        do_branch(4'b0000, 16'd32, "bne_taken_pc");

        // BRA imm=5 at 32, then fetch and branch in the same cycle
        do_fetch(32'h4F00_0005, 1'b1, 0, 2, 1, 16'd32, 1'b0, 4'd0, 32'h4F00_0005, 16'd33, 1'b0);
        do_fetch(32'h9000_0000, 1'b1, 0, 2, 1, 16'd5, 1'b1, 4'b0001, 32'h9000_0000, 16'd6, 1'b0);

        // Non-branch opcode ignores br_eval
        do_branch(4'b1111, 16'd6, "nonbranch_pc");

        // Reset during a stalled fetch
        @(negedge clk);
        mem_auto  = 1'b0;
        im_ready  = 1'b0;
        fetch_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (2) @(negedge clk);
        chk("stall_im_req", 64'(im_req), 64'(1));
        #2 rst_f = 1'b0;
        #1;
        chk("midrst_im_req", 64'(im_req), 64'(0));
        chk("midrst_pc",     64'(pc), 64'(0));
        chk("midrst_opcode", 64'(opcode), 64'(0));
        @(negedge clk);
        rst_f    = 1'b1;
        im_ready = 1'b1;
        im_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        chk("late_ready_pc",     64'(pc), 64'(0));
        chk("late_ready_opcode", 64'(opcode), 64'(0));
        chk("late_ready_req",    64'(im_req), 64'(0));
        chk("late_ready_done",   64'(fetch_done), 64'(0));
        im_ready = 1'b0;

        // Reload a real instruction so a NOOP load is visible
        do_fetch(32'h2345_6789, 1'b1, 0, 2, 1, 16'd0, 1'b0, 4'd0, 32'h2345_6789, 16'd1, 1'b0);

`ifdef IFETCH_TIMEOUT_EN
        // 15-cycle stall: NOOP loaded, pc unchanged, sticky error
        do_fetch(32'h0, 1'b0, 0, 16, 15, 16'd1, 1'b0, 4'd0, 32'h0, 16'd1, 1'b1);
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(fetch_err), 64'(1));
        chk("timeout_opcode", 64'(opcode), 64'(0));
`else
        // Without the timeout the request waits indefinitely
        @(negedge clk);
        mem_auto  = 1'b0;
        im_ready  = 1'b0;
        fetch_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (20) @(negedge clk);
        chk("no_timeout_req", 64'(im_req), 64'(1));
        chk("no_timeout_err", 64'(fetch_err), 64'(0));
        chk("no_timeout_opcode", 64'(opcode), 64'(2));
        rst_f = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
